// File: rtl/fsqrt_iter.sv
// fsqrt_iter: iterative IEEE-754 single-precision square root.
// Uses restoring digit recurrence and resolves BPC root bits per cycle.
// Denormal inputs are flushed to zero. NaN and negative inputs give a quiet NaN
// and raise the exception flag.
// Build option: define FSQRT_RNE_EN to round to nearest-even. When it is not
// defined, the root is truncated toward zero.
module fsqrt_iter #(
    parameter int unsigned BPC   = 1,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic             exception,
    output logic [TAG_W-1:0] out_tag
);

    // 24 significand bits plus guard and round bits
    localparam int unsigned ITER = 26 / BPC;
    // Remainder never exceeds 2*root + 1, so 27 bits are enough; after the
    // shift it needs 29 bits, and one more bit gives headroom
    localparam int unsigned RW   = 30;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t        state;
    logic [4:0]    cnt;
    logic [51:0]   rad;
    logic [RW-1:0] rem;
    logic [25:0]   root;
    logic [7:0]    res_exp;

    logic          x_sign;
    logic [7:0]    x_exp;
    logic [22:0]   x_frac;
    logic          is_special;
    logic [31:0]   spec_y;
    logic          spec_exc;
    logic [51:0]   load_rad;
    logic [7:0]    load_exp;

    logic [51:0]   rad_nxt;
    logic [RW-1:0] rem_nxt;
    logic [25:0]   root_nxt;
    logic [RW-1:0] sh_rem;
    logic [RW-1:0] trial;

    logic [22:0]   res_frac;
    logic [7:0]    res_exp_out;

    assign x_sign = x[31];
    assign x_exp  = x[30:23];
    assign x_frac = x[22:0];

    // Decode zero/denormal, infinity, NaN and negative operands into a finished result
    always_comb begin
        is_special = 1'b0;
        spec_y     = 32'h7FC0_0000;
        spec_exc   = 1'b0;
        if (x_exp == 8'h00) begin
            is_special = 1'b1;
            spec_y     = {x_sign, 31'd0};
            spec_exc   = 1'b0;
        end else if (x_exp == 8'hFF && x_frac != 23'd0) begin
            is_special = 1'b1;
            spec_y     = 32'h7FC0_0000;
            spec_exc   = 1'b1;
        end else if (x_sign) begin
            is_special = 1'b1;
            spec_y     = 32'h7FC0_0000;
            spec_exc   = 1'b1;
        end else if (x_exp == 8'hFF) begin
            is_special = 1'b1;
            spec_y     = 32'h7F80_0000;
            spec_exc   = 1'b0;
        end
    end

    // Scale the radicand so the integer root holds 26 bits. When the unbiased
    // exponent is odd (the biased exponent is even), shift left one more bit.
    // The halved exponent reduces to (exp >> 1) + 63 + exp[0].
    always_comb begin
        if (x_exp[0]) begin
            load_rad = {1'b0, 1'b1, x_frac, 27'd0};
        end else begin
            load_rad = {1'b1, x_frac, 28'd0};
        end
        load_exp = {1'b0, x_exp[7:1]} + 8'd63 + {7'd0, x_exp[0]};
    end

    // Restoring recurrence: BPC digit steps chained within one cycle
    always_comb begin
        rem_nxt  = rem;
        root_nxt = root;
        rad_nxt  = rad;
        sh_rem   = '0;
        trial    = '0;
        for (int unsigned i = 0; i < BPC; i++) begin
            sh_rem  = {rem_nxt[RW-3:0], rad_nxt[51:50]};
            trial   = {{(RW-28){1'b0}}, root_nxt, 2'b01};
            rad_nxt = {rad_nxt[49:0], 2'b00};
            if (sh_rem >= trial) begin
                rem_nxt  = sh_rem - trial;
                root_nxt = {root_nxt[24:0], 1'b1};
            end else begin
                rem_nxt  = sh_rem;
                root_nxt = {root_nxt[24:0], 1'b0};
            end
        end
    end

`ifdef FSQRT_RNE_EN
    logic        round_up;
    logic [24:0] mant_rnd;

    // Round to nearest-even from guard, round and sticky; a carry-out renormalises
    always_comb begin
        round_up    = root_nxt[1] & (root_nxt[0] | (|rem_nxt) | root_nxt[2]);
        mant_rnd    = {1'b0, root_nxt[25:2]} + {24'd0, round_up};
        res_frac    = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
        res_exp_out = res_exp + {7'd0, mant_rnd[24]};
    end
`else
    // Truncate toward zero: drop the guard and round bits and ignore the remainder
    always_comb begin
        res_frac    = root_nxt[24:2];
        res_exp_out = res_exp;
    end
`endif

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= StIdle;
            cnt       <= 5'd0;
            rad       <= '0;
            rem       <= '0;
            root      <= '0;
            res_exp   <= 8'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y         <= 32'd0;
            exception <= 1'b0;
            out_tag   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        out_tag  <= in_tag;
                        if (is_special) begin
                            y         <= spec_y;
                            exception <= spec_exc;
                            out_valid <= 1'b1;
                            state     <= StDone;
                        end else begin
                            cnt     <= 5'(ITER);
                            rad     <= load_rad;
                            rem     <= '0;
                            root    <= '0;
                            res_exp <= load_exp;
                            state   <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    rad  <= rad_nxt;
                    rem  <= rem_nxt;
                    root <= root_nxt;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        // Last digits: package the result on the same edge
                        y         <= {1'b0, res_exp_out, res_frac};
                        exception <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state     <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsqrt_iter.sv
// tb_fsqrt_iter: self-checking bench for fsqrt_iter.
// Instance dut1 uses BPC=1 and instance dut2 uses BPC=2.
// Expected results come from a real-number sqrt reference model.
module tb_fsqrt_iter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid_a  [2];
    logic        in_ready_a  [2];
    logic [31:0] x_a         [2];
    logic [3:0]  in_tag_a    [2];
    logic        out_valid_a [2];
    logic        out_ready_a [2];
    logic [31:0] y_a         [2];
    logic        exc_a       [2];
    logic [3:0]  out_tag_a   [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fsqrt_iter #(.BPC(1), .TAG_W(4)) dut1 (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid_a[0]),
        .in_ready  (in_ready_a[0]),
        .x         (x_a[0]),
        .in_tag    (in_tag_a[0]),
        .out_valid (out_valid_a[0]),
        .out_ready (out_ready_a[0]),
        .y         (y_a[0]),
        .exception (exc_a[0]),
        .out_tag   (out_tag_a[0])
    );

    fsqrt_iter #(.BPC(2), .TAG_W(4)) dut2 (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid_a[1]),
        .in_ready  (in_ready_a[1]),
        .x         (x_a[1]),
        .in_tag    (in_tag_a[1]),
        .out_valid (out_valid_a[1]),
        .out_ready (out_ready_a[1]),
        .y         (y_a[1]),
        .exception (exc_a[1]),
        .out_tag   (out_tag_a[1])
    );

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp_v);
        end
    endtask

    // Reference model: returns {exception, y}
    function automatic logic [32:0] model(input logic [31:0] xv);
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        logic [63:0] d;
        logic [63:0] rb;
        real         r;
        logic [10:0] de;
        logic [30:0] mag;
        logic [28:0] rest;
        s = xv[31];
        e = xv[30:23];
        f = xv[22:0];
        if (e == 8'h00) return {1'b0, s, 31'd0};
        if (e == 8'hFF && f != 23'd0) return {1'b1, 32'h7FC0_0000};
        if (s) return {1'b1, 32'h7FC0_0000};
        if (e == 8'hFF) return {1'b0, 32'h7F80_0000};
        d    = {1'b0, 11'({3'b000, e} + 11'd896), f, 29'd0};
        r    = $sqrt($bitstoreal(d));
        rb   = $realtobits(r);
        de   = rb[62:52];
        mag  = {8'(de - 11'd896), rb[51:29]};
        rest = rb[28:0];
`ifdef FSQRT_RNE_EN
        if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && mag[0])) mag = mag + 31'd1;
`else
        rest = '0;
`endif
        return {1'b0, 1'b0, mag};
    endfunction

    task automatic start_op(input int w, input logic [31:0] xv, input logic [3:0] tg);
        int guard;
        guard = 0;
        @(negedge clk);
        while (in_ready_a[w] !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_op", 32'(in_ready_a[w]), 32'd1);
        in_valid_a[w] = 1'b1;
        x_a[w]        = xv;
        in_tag_a[w]   = tg;
        @(posedge clk);
        #1;
        in_valid_a[w] = 1'b0;
    endtask

    // Latency counts the accept edge as 1
    task automatic wait_done(input int w, output int lat);
        lat = 1;
        while (out_valid_a[w] !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid_seen", 32'(out_valid_a[w]), 32'd1);
    endtask

    task automatic take(input int w);
        @(negedge clk);
        out_ready_a[w] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_a[w] = 1'b0;
        chk("out_valid_cleared", 32'(out_valid_a[w]), 32'd0);
    endtask

    task automatic do_op(input int w, input logic [31:0] xv, input logic [3:0] tg,
                         output logic [31:0] ry, output logic re, output logic [3:0] rt,
                         output int lat);
        start_op(w, xv, tg);
        wait_done(w, lat);
        ry = y_a[w];
        re = exc_a[w];
        rt = out_tag_a[w];
        take(w);
    endtask

    task automatic dir_op(input string nm, input int w, input logic [31:0] xv,
                          input logic [3:0] tg, input logic [31:0] ey, input logic ee,
                          input int el);
        logic [31:0] ry;
        logic        re;
        logic [3:0]  rt;
        int          lat;
        do_op(w, xv, tg, ry, re, rt, lat);
        chk({nm, "_y"}, ry, ey);
        chk({nm, "_exc"}, 32'(re), 32'(ee));
        chk({nm, "_tag"}, 32'(rt), 32'(tg));
        chk({nm, "_lat"}, 32'(lat), 32'(el));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ry;
        logic        rexc;
        logic [3:0]  rtag;
        int          lat;
        int          el;
        logic [32:0] m;
        logic [31:0] xv;
        logic [3:0]  tg;
        bit          seen;
        bit          spec;

        for (int w = 0; w < 2; w++) begin
            in_valid_a[w]  = 1'b0;
            x_a[w]         = 32'd0;
            in_tag_a[w]    = 4'd0;
            out_ready_a[w] = 1'b0;
        end

        // Reset state
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid_a[0]), 32'd0);
        chk("rst_y", y_a[0], 32'd0);
        chk("rst_exc", 32'(exc_a[0]), 32'd0);
        chk("rst_tag", 32'(out_tag_a[0]), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready0", 32'(in_ready_a[0]), 32'd1);
        chk("rst_in_ready1", 32'(in_ready_a[1]), 32'd1);

        // Directed vectors
        dir_op("sqrt4", 0, 32'h4080_0000, 4'd3, 32'h4000_0000, 1'b0, 27);
        dir_op("sqrt2", 0, 32'h4000_0000, 4'd1, 32'h3FB5_04F3, 1'b0, 27);
        dir_op("sqrt9", 0, 32'h4110_0000, 4'd2, 32'h4040_0000, 1'b0, 27);
        dir_op("quarter", 0, 32'h3E80_0000, 4'd4, 32'h3F00_0000, 1'b0, 27);
        dir_op("minnorm", 0, 32'h0080_0000, 4'd8, 32'h2000_0000, 1'b0, 27);
        dir_op("neg4", 0, 32'hC080_0000, 4'd5, 32'h7FC0_0000, 1'b1, 1);
        dir_op("negzero", 0, 32'h8000_0000, 4'd6, 32'h8000_0000, 1'b0, 1);
        dir_op("inf", 0, 32'h7F80_0000, 4'd7, 32'h7F80_0000, 1'b0, 1);
        dir_op("nan", 0, 32'h7FC0_0001, 4'd9, 32'h7FC0_0000, 1'b1, 1);
        dir_op("denorm", 0, 32'h0040_0000, 4'd10, 32'h0000_0000, 1'b0, 1);
        dir_op("neginf", 1, 32'hFF80_0000, 4'd11, 32'h7FC0_0000, 1'b1, 1);
        dir_op("sqrt4_b2", 1, 32'h4080_0000, 4'd12, 32'h4000_0000, 1'b0, 14);
        dir_op("sqrt2_b2", 1, 32'h4000_0000, 4'd13, 32'h3FB5_04F3, 1'b0, 14);

        // Hold in DONE with out_ready low; in_valid during CALC must be ignored
        start_op(0, 32'h4110_0000, 4'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid_a[0] = 1'b1;
            x_a[0]        = 32'h4080_0000;
            in_tag_a[0]   = 4'd9;
            @(posedge clk);
            #1;
            chk("calc_in_ready", 32'(in_ready_a[0]), 32'd0);
        end
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        wait_done(0, lat);
        ry   = y_a[0];
        rexc = exc_a[0];
        rtag = out_tag_a[0];
        chk("hold_y_value", ry, 32'h4040_0000);
        chk("hold_tag_value", 32'(rtag), 32'd5);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid_a[0]), 32'd1);
            chk("hold_y", y_a[0], ry);
            chk("hold_exc", 32'(exc_a[0]), 32'(rexc));
            chk("hold_tag", 32'(out_tag_a[0]), 32'(rtag));
            chk("hold_in_ready", 32'(in_ready_a[0]), 32'd0);
        end
        take(0);
        chk("after_take_in_ready", 32'(in_ready_a[0]), 32'd1);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid_a[0] === 1'b1) seen = 1'b1;
        end
        chk("ignored_input_no_result", 32'(seen), 32'd0);

        // Reset during CALC aborts the operation
        start_op(0, 32'h4080_0000, 4'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid_a[0]), 32'd0);
        chk("abort_y", y_a[0], 32'd0);
        chk("abort_tag", 32'(out_tag_a[0]), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready", 32'(in_ready_a[0]), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid_a[0] === 1'b1) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);

        // Reset during DONE drops the pending result
        start_op(1, 32'h7F80_0000, 4'd2);
        chk("done_valid_pre", 32'(out_valid_a[1]), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("done_abort_valid", 32'(out_valid_a[1]), 32'd0);
        chk("done_abort_y", y_a[1], 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("done_abort_in_ready", 32'(in_ready_a[1]), 32'd1);

        // Random sweep over both instances
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 40; k++) begin
                xv[31]    = ($urandom_range(0, 3) == 0);
                xv[30:23] = 8'($urandom_range(1, 254));
                xv[22:0]  = 23'($urandom);
                tg        = 4'($urandom);
                m         = model(xv);
                spec      = xv[31];
                el        = spec ? 1 : (26 / (w + 1)) + 1;
                do_op(w, xv, tg, ry, rexc, rtag, lat);
                chk("rand_y", ry, m[31:0]);
                chk("rand_exc", 32'(rexc), 32'(m[32]));
                chk("rand_tag", 32'(rtag), 32'(tg));
                chk("rand_lat", 32'(lat), 32'(el));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fsqrt_iter.md
FSQRT_ITER -- requirements
Module: fsqrt_iter

Interface
REQ-001 Parameter BPC, default 1: root bits resolved per iteration cycle; legal values 1 and 2.
REQ-002 Parameter TAG_W, default 4: width of the opaque tag carried alongside each operation.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset; asynchronous and active-low.
REQ-005 in_valid  input  1  the operand on x and in_tag is valid.
REQ-006 in_ready  output  1  the block accepts an operand this cycle.
REQ-007 x  input  32  IEEE-754 single-precision operand.
REQ-008 in_tag  input  TAG_W  tag returned unchanged with the result.
REQ-009 out_valid  output  1  y, exception and out_tag are valid.
REQ-010 out_ready  input  1  the consumer takes the result this cycle.
REQ-011 y  output  32  single-precision square root.
REQ-012 exception  output  1  invalid-operation flag for this result.
REQ-013 out_tag  output  TAG_W  tag of the operation being presented.

Function
REQ-014 FSM has three states: IDLE, CALC and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; an input is accepted when in_valid and in_ready are both 1.
REQ-016 On accept with a special operand: go to DONE on the next edge (latency 1).
REQ-017 On accept with a normal operand: load the iteration counter with ITER = 26/BPC (26 for BPC=1, 13 for BPC=2) and go to CALC.
REQ-018 In CALC, each cycle SHALL resolve BPC root bits by restoring digit recurrence and decrement the counter; at count 1, go to DONE.
REQ-019 Normal-operand latency from accept edge to out_valid SHALL be ITER+1 cycles.
REQ-020 In DONE, out_valid=1 and y, exception and out_tag SHALL be held stable until out_ready=1; then go to IDLE.
REQ-021 Back-to-back rate: at most one accept per ITER+2 cycles; in_valid asserted in a non-IDLE state SHALL be ignored without side effects.
REQ-022 Exponent rule: e = exp-127; if e is odd, shift the significand left by 1 and decrement e; result exponent = e/2+127.
REQ-023 Root precision: 24 significand bits plus guard and round bits; sticky = (final remainder != 0).
REQ-024 Special: exp=0 (either sign) -> y = sign,0x00,0; exception=0 (denormals flushed to zero).
REQ-025 Special: +Inf -> y = 0x7F800000; exception=0.
REQ-026 Special: NaN, or negative with exp != 0 -> y = 0x7FC00000; exception=1.
REQ-027 Positive normal results SHALL never overflow or underflow; no other flag is raised.

Reset
REQ-028 While rstn=0: state=IDLE, counter=0, out_valid=0, y=0, exception=0, out_tag=0; in_ready SHALL be 1 after release.
REQ-029 Reset asserted during CALC or DONE SHALL abort the operation with no result emitted.

Configuration
REQ-030 Macro FSQRT_RNE_EN defined: the root is rounded to nearest-even from guard, round and sticky, with mantissa carry-out incrementing the exponent; results are bit-exact to IEEE sqrt.
REQ-031 Macro FSQRT_RNE_EN undefined: the root is truncated toward zero; the error is below 1 ulp and the rounding logic is absent.

Verification
REQ-032 x=0x40800000 (4.0), tag=3 -> y=0x40000000, exception=0, out_tag=3, out_valid exactly 27 cycles after accept (BPC=1).
REQ-033 x=0x40000000 (2.0), FSQRT_RNE_EN defined -> y=0x3FB504F3; undefined -> y=0x3FB504F3 or 0x3FB504F2, within 1 ulp.
REQ-034 x=0xC0800000 -> y=0x7FC00000, exception=1 after 1 cycle; x=0x80000000 -> y=0x80000000, exception=0.
REQ-035 x=0x7F800000 -> 0x7F800000; x=0x7FC00001 -> 0x7FC00000 with exception=1; x=0x00400000 -> 0x00000000.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> y, exception and out_tag stable and in_ready=0 throughout; drive in_valid during CALC -> input ignored.
REQ-037 Assert rstn=0 mid-CALC -> out_valid=0 immediately, in_ready=1 after release, no stale result; random sweep of exponents 1..254, both signs, BPC=1 and BPC=2 -> matches a real-number sqrt model.
